// File: rtl/debug_dump_rx.sv
// debug_dump_rx: reassembles the debug unit's UART dump (MSB byte first) into a capture bank,
// exposing PC/cycle words and reporting frame completion and inter-byte timeouts.
module debug_dump_rx #(
    parameter int DATA_BITS      = 8,
    parameter int NBITS          = 32,
    parameter int MEM_REG_SIZE   = 32,
    parameter int MEM_DATA_SIZE  = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int FRAME_WORDS   = 2 + MEM_REG_SIZE + MEM_DATA_SIZE,
    localparam int ADDR_BITS     = $clog2(FRAME_WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    input  logic                 i_clear,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic                 o_uart_rx_reset,
    output logic [NBITS-1:0]     o_rd_data,
    output logic [NBITS-1:0]     o_pc,
    output logic [NBITS-1:0]     o_cycles,
    output logic                 o_frame_done,
    output logic                 o_frame_error,
    output logic [7:0]           o_frame_count,
    output logic                 o_busy,
    output logic [2:0]           o_state
);
    localparam logic [2:0] RECV    = 3'd0;
    localparam logic [2:0] RELEASE = 3'd1;
    localparam logic [2:0] STORE   = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] ABORT   = 3'd4;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [2:0]           state;
    logic [1:0]           byte_cnt;
    logic [ADDR_BITS-1:0] word_cnt;
    logic [TW-1:0]        timer;
    logic [NBITS-1:0]     shift_reg;
    logic [NBITS-1:0]     bank [FRAME_WORDS];
    logic                 store_en;
    logic                 rd_valid;

    assign o_busy   = (word_cnt != '0) || (byte_cnt != '0);
    assign o_state  = state;
    assign store_en = i_reset && !i_clear && (state == STORE);
    assign rd_valid = {1'b0, i_rd_addr} < (ADDR_BITS+1)'(FRAME_WORDS);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state           <= RECV;
            byte_cnt        <= '0;
            word_cnt        <= '0;
            timer           <= '0;
            shift_reg       <= '0;
            o_uart_rx_reset <= 1'b0;
            o_pc            <= '0;
            o_cycles        <= '0;
            o_frame_done    <= 1'b0;
            o_frame_error   <= 1'b0;
            o_frame_count   <= '0;
        end else if (i_clear) begin
            state           <= RECV;
            byte_cnt        <= '0;
            word_cnt        <= '0;
            timer           <= '0;
            o_uart_rx_reset <= 1'b1;
            o_frame_done    <= 1'b0;
            o_frame_error   <= 1'b0;
        end else begin
            o_frame_done  <= 1'b0;
            o_frame_error <= 1'b0;
            case (state)
                RECV: begin
                    o_uart_rx_reset <= i_uart_rx_ready;
                    if (i_uart_rx_ready) begin
                        shift_reg <= {shift_reg[NBITS-DATA_BITS-1:0], i_uart_rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        timer     <= '0;
                        state     <= RELEASE;
                    end else if (o_busy) begin
                        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            state         <= ABORT;
                            o_frame_error <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    o_uart_rx_reset <= i_uart_rx_ready;
                    if (!i_uart_rx_ready)
                        state <= (byte_cnt == 2'd0) ? STORE : RECV;
                end
                STORE: begin
                    if (word_cnt == ADDR_BITS'(0)) o_pc <= shift_reg;
                    if (word_cnt == ADDR_BITS'(1)) o_cycles <= shift_reg;
                    if (word_cnt == ADDR_BITS'(FRAME_WORDS - 1)) begin
                        state         <= DONE;
                        o_frame_done  <= 1'b1;
                        o_frame_count <= o_frame_count + 8'd1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= RECV;
                    end
                end
                DONE: begin
                    word_cnt <= '0;
                    state    <= RECV;
                end
                ABORT: begin
                    word_cnt <= '0;
                    byte_cnt <= '0;
                    timer    <= '0;
                    state    <= RECV;
                end
                default: state <= RECV;
            endcase
        end
    end

    // Bank is deliberately left out of reset so a dump survives a host-side reset.
    always_ff @(posedge i_clk) begin
        if (store_en)
            bank[word_cnt] <= shift_reg;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            o_rd_data <= '0;
        else
            o_rd_data <= rd_valid ? bank[i_rd_addr] : '0;
    end
endmodule

// File: tb/tb_debug_dump_rx.sv
// tb_debug_dump_rx: directed checks of frame capture, byte order, handshake, timeout, reset/clear and wrap.
module tb_debug_dump_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic       clear = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [1:0] s_rd_addr = '0;
    logic       sel = 1'b0;

    logic        rx_reset, done, err, busy;
    logic [31:0] rd_data, pc, cycles;
    logic [7:0]  count;
    logic [2:0]  state;
    logic        s_rx_reset, s_done, s_err, s_busy;
    logic [31:0] s_rd_data, s_pc, s_cycles;
    logic [7:0]  s_count;
    logic [2:0]  s_state;
    logic        ack;

    int tests = 0, fails = 0;
    int done_cnt = 0, err_cnt = 0, s_done_cnt = 0, s_err_cnt = 0;

    always #5 clk = ~clk;
    assign ack = sel ? s_rx_reset : rx_reset;

    debug_dump_rx #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_uart_rx_ready(rx_ready), .i_uart_rx_data(rx_data),
        .i_clear(clear), .i_rd_addr(rd_addr), .o_uart_rx_reset(rx_reset), .o_rd_data(rd_data),
        .o_pc(pc), .o_cycles(cycles), .o_frame_done(done), .o_frame_error(err),
        .o_frame_count(count), .o_busy(busy), .o_state(state)
    );

    debug_dump_rx #(.MEM_REG_SIZE(1), .MEM_DATA_SIZE(1), .TIMEOUT_CYCLES(16)) dut_s (
        .i_clk(clk), .i_reset(rst_n), .i_uart_rx_ready(rx_ready), .i_uart_rx_data(rx_data),
        .i_clear(clear), .i_rd_addr(s_rd_addr), .o_uart_rx_reset(s_rx_reset), .o_rd_data(s_rd_data),
        .o_pc(s_pc), .o_cycles(s_cycles), .o_frame_done(s_done), .o_frame_error(s_err),
        .o_frame_count(s_count), .o_busy(s_busy), .o_state(s_state)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (s_done) s_done_cnt++;
        if (s_err) s_err_cnt++;
    end

    function automatic logic [31:0] word_of(input int k, input int seed);
        if (k == 0) return 32'h10 + seed;
        if (k == 1) return 32'h5 + seed;
        if (k < 34) return k - 2 + seed;
        return 32'h100 + k - 34 + seed;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data = b;
        rx_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 50);
        tests++;
        if (!ack) begin
            fails++;
            $display("FAIL ack_timeout: rx_reset=%b required 1 within 50 cycles", ack);
        end
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
    endtask

    task automatic send_frame(input int nw, input int seed);
        for (int k = 0; k < nw; k++) send_word(word_of(k, seed));
        tick(3);
    endtask

    task automatic send_bytes(input int n, input int seed);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = word_of(i / 4, seed);
            send_byte(w[31-8*(i%4) -: 8]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({rx_reset, rd_data, pc, cycles, done, err, count, busy, state} !== '0) begin
            fails++;
            $display("FAIL %s: rx_reset=%b rd=%h pc=%h cyc=%h done=%b err=%b cnt=%0d busy=%b st=%0d required all 0",
                     tag, rx_reset, rd_data, pc, cycles, done, err, count, busy, state);
        end
    endtask

    task automatic check_frame(input string tag, input int seed, input logic [7:0] exp_cnt);
        tests++;
        if (pc !== word_of(0, seed) || cycles !== word_of(1, seed) || count !== exp_cnt) begin
            fails++;
            $display("FAIL %s: pc=%h cyc=%h cnt=%0d required pc=%h cyc=%h cnt=%0d",
                     tag, pc, cycles, count, word_of(0, seed), word_of(1, seed), exp_cnt);
        end
    endtask

    task automatic test_reset();
        tick(2);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_full_frame();
        int d0;
        logic [31:0] exp [3];
        logic [5:0]  addr [3];
        d0 = done_cnt;
        send_frame(50, 0);
        tests++;
        if (done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL frame_done_pulses: got %0d required 1", done_cnt - d0);
        end
        tests++;
        if (pc !== 32'h10 || cycles !== 32'h5 || count !== 8'd1) begin
            fails++;
            $display("FAIL frame_words: pc=%h cyc=%h cnt=%0d required 10 5 1", pc, cycles, count);
        end
        addr = '{6'd9, 6'd37, 6'd50};
        exp  = '{32'h7, 32'h103, 32'h0};
        for (int i = 0; i < 3; i++) begin
            rd_addr = addr[i];
            tick(1);
            tests++;
            if (rd_data !== exp[i]) begin
                fails++;
                $display("FAIL bank_read[%0d]: got %h required %h", addr[i], rd_data, exp[i]);
            end
        end
    endtask

    task automatic test_byte_order();
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        tick(2);
        tests++;
        if (pc !== 32'h10) begin
            fails++;
            $display("FAIL pc_after_3_bytes: got %h required 00000010", pc);
        end
        send_byte(8'hEF);
        tick(2);
        tests++;
        if (pc !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL pc_byte_order: got %h required deadbeef", pc);
        end
    endtask

    task automatic test_sticky_ready();
        int held;
        rx_data = 8'hAA;
        rx_ready = 1'b1;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (rx_reset === 1'b1) held++;
        end
        tests++;
        if (held !== 10) begin
            fails++;
            $display("FAIL sticky_ack: rx_reset high %0d of 10 cycles required 10", held);
        end
        rx_ready = 1'b0;
        tick(1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        tick(2);
        tests++;
        if (cycles !== 32'hAA112233) begin
            fails++;
            $display("FAIL sticky_single_capture: cycles=%h required aa112233", cycles);
        end
    endtask

    task automatic test_timeout();
        int first, pulses;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tests++;
        if (rx_reset !== 1'b1 || busy !== 1'b0 || state !== 3'd0) begin
            fails++;
            $display("FAIL clear_idle: rx_reset=%b busy=%b st=%0d required 1 0 0", rx_reset, busy, state);
        end
        tick(1);
        send_bytes(5, 0);
        first = 0;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (err) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        tests++;
        if (pulses !== 1 || first !== 16) begin
            fails++;
            $display("FAIL timeout_pulse: pulses=%0d at cycle %0d required 1 at 16", pulses, first);
        end
        tests++;
        if (busy !== 1'b0 || count !== 8'd1) begin
            fails++;
            $display("FAIL timeout_after: busy=%b cnt=%0d required 0 1", busy, count);
        end
        send_frame(50, 1);
        check_frame("frame_after_timeout", 1, 8'd2);
        rd_addr = 6'd20;
        tick(1);
        tests++;
        if (rd_data !== word_of(20, 1)) begin
            fails++;
            $display("FAIL read_after_timeout: got %h required %h", rd_data, word_of(20, 1));
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bytes(37, 5);
        rst_n = 1'b0;
        tick(1);
        check_reset_outputs("reset_mid_frame");
        rst_n = 1'b1;
        tick(1);
        send_frame(50, 2);
        check_frame("frame_after_reset", 2, 8'd1);
        rd_addr = 6'd40;
        tick(1);
        tests++;
        if (rd_data !== 32'h108) begin
            fails++;
            $display("FAIL read_after_reset: got %h required 00000108", rd_data);
        end
    endtask

    task automatic test_clear_mid_frame();
        int d0, e0;
        send_bytes(37, 6);
        d0 = done_cnt;
        e0 = err_cnt;
        rx_data = 8'h77;
        rx_ready = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        rx_ready = 1'b0;
        tests++;
        if (busy !== 1'b0 || state !== 3'd0 || rx_reset !== 1'b1) begin
            fails++;
            $display("FAIL clear_drops_byte: busy=%b st=%0d rx_reset=%b required 0 0 1", busy, state, rx_reset);
        end
        tick(1);
        send_frame(50, 3);
        check_frame("frame_after_clear", 3, 8'd2);
        tests++;
        if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
            fails++;
            $display("FAIL clear_no_pulse: done+%0d err+%0d required 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        sel = 1'b1;
        s_done_cnt = 0;
        s_err_cnt = 0;
        for (int f = 0; f < 256; f++)
            for (int k = 0; k < 4; k++) send_word(word_of(k, f));
        tick(3);
        tests++;
        if (s_done_cnt !== 256 || s_count !== 8'd0 || s_err_cnt !== 0) begin
            fails++;
            $display("FAIL back_to_back: done=%0d cnt=%0d err=%0d required 256 0 0", s_done_cnt, s_count, s_err_cnt);
        end
        tests++;
        if (s_pc !== word_of(0, 255) || s_cycles !== word_of(1, 255)) begin
            fails++;
            $display("FAIL back_to_back_data: pc=%h cyc=%h required %h %h", s_pc, s_cycles, word_of(0, 255), word_of(1, 255));
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_byte_order();
        test_sticky_ready();
        test_timeout();
        test_reset_mid_frame();
        test_clear_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/debug_dump_rx.md
# debug_dump_rx

Receive-side counterpart of the MIPS debug unit's UART dump: consumes the byte stream the debug unit transmits after a halt or a step (PC, cycle count, 32 registers, 16 data-memory words; each word MSB byte first). It reassembles bytes into 32-bit words and stores one full frame in a capture bank. It exposes PC and cycle count directly and reports frame completion and framing errors. It sits behind a UART RX on a host-side/loopback FPGA image or in system benches, and uses the same RX ready/reset handshake the debug unit uses.

## Interface
- DATA_BITS, 8, UART byte width
- NBITS, 32, word width
- MEM_REG_SIZE, 32, register words per frame
- MEM_DATA_SIZE, 16, data-memory words per frame
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a frame
- FRAME_WORDS (localparam) = 2 + MEM_REG_SIZE + MEM_DATA_SIZE (50); ADDR_BITS = $clog2(FRAME_WORDS) (6)

- i_clk  in  1  single clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_uart_rx_ready  in  1  RX byte available (level, held until cleared)
- i_uart_rx_data  in  DATA_BITS  RX byte, valid while i_uart_rx_ready=1
- i_clear  in  1  abort current frame, zero counters (not the bank)
- i_rd_addr  in  ADDR_BITS  capture-bank read address
- o_uart_rx_reset  out  1  byte acknowledge/clear to RX
- o_rd_data  out  NBITS  registered bank read data
- o_pc  out  NBITS  word 0 of the frame
- o_cycles  out  NBITS  word 1 of the frame
- o_frame_done  out  1  one-cycle pulse, frame complete
- o_frame_error  out  1  one-cycle pulse, inter-byte timeout
- o_frame_count  out  8  completed frames, wraps 255→0
- o_busy  out  1  high while word_cnt≠0 or byte_cnt≠0
- o_state  out  3  current FSM state code

## Operation
- Word map: 0=PC, 1=cycles, 2..33=reg[0..31], 34..49=mem[0..15].
- Assembly: shift_reg <= {shift_reg[23:0], byte}; 2-bit byte_cnt wraps 3→0, and the wrap means a word is complete. The first byte received is bits [31:24].
- FSM (codes): RECV=0, RELEASE=1, STORE=2, DONE=3, ABORT=4.
  - RECV: o_uart_rx_reset=0. If i_uart_rx_ready=1, shift in the byte, byte_cnt++, o_uart_rx_reset<=1, go to RELEASE.
  - RELEASE: hold o_uart_rx_reset=1 until i_uart_rx_ready=0. Then, if byte_cnt==0, go to STORE; otherwise go to RECV. A byte held for many cycles is captured exactly once.
  - STORE: bank[word_cnt]<=shift_reg. If word_cnt is 0, also load o_pc; if it is 1, also load o_cycles. If word_cnt==FRAME_WORDS-1, go to DONE; otherwise word_cnt++ and go to RECV.
  - DONE: o_frame_done=1, o_frame_count++, word_cnt<=0, then go to RECV.
  - ABORT: o_frame_error=1, word_cnt<=0, byte_cnt<=0, timer<=0, then go to RECV.
- Timeout:
  - The timer counts cycles in RECV while o_busy=1 and clears whenever a byte is accepted.
  - When timer reaches TIMEOUT_CYCLES-1, go to ABORT.
  - The timer does not run when o_busy=0, so the bus may idle indefinitely between frames.
- i_clear behaviour:
  - Any state goes to RECV with word_cnt, byte_cnt and timer zeroed, and o_uart_rx_reset=1 for that cycle.
  - No error or done pulse is generated.
  - i_clear wins over a simultaneous byte, timeout or DONE.
- Partial frames are not committed elsewhere. Bank words already written by an aborted frame stay until overwritten.
- Read port: o_rd_data <= bank[i_rd_addr] every cycle. An address ≥ FRAME_WORDS returns 0. A read and a STORE to the same address in the same cycle returns the old value.

## Timing
- Reset (i_reset=0 at an edge): state=RECV.
  - Zeroed: o_uart_rx_reset, o_rd_data, o_pc, o_cycles, o_frame_done, o_frame_error, o_frame_count, o_busy, o_state, and all counters.
  - Bank contents are not reset.
- A reset during a frame discards the partial word and the frame.
- Byte acceptance: RX ready is sampled at edge t; o_uart_rx_reset=1 from t+1 until the edge after ready is seen low.
- Word commit: STORE occupies one cycle after the 4th byte's RELEASE. The bank, o_pc and o_cycles update at the edge ending STORE.
- Frame: o_frame_done is high for the single cycle after the 50th STORE, and o_frame_count updates at that edge.
- Minimum per byte: 2 cycles (RECV, RELEASE); per word add 1 (STORE).
- o_rd_data latency: 1 cycle after i_rd_addr.

## Test plan
- Full frame, RX model releases ready one cycle after ack; PC=0x00000010, cycles=0x00000005, reg k=k, mem k=0x100+k. Required response:
  - o_frame_done pulses once; o_frame_count=1; o_pc=0x10; o_cycles=0x5.
  - Reading addr 9 gives 7; addr 37 gives 0x103; addr 50 gives 0.
- Byte order: first word bytes 0xDE,0xAD,0xBE,0xEF → o_pc=0xDEADBEEF after STORE. o_pc must be unchanged after only 3 bytes.
- Sticky ready: hold i_uart_rx_ready=1 with byte 0xAA for 10 cycles. Required response: byte_cnt advances by exactly 1 and o_uart_rx_reset stays 1 for all 10 cycles.
- Timeout with TIMEOUT_CYCLES=16: send 5 bytes, then go idle. Required response:
  - o_frame_error pulses once, 16 cycles after the last accept; o_busy=0; o_frame_count unchanged.
  - A following 200-byte frame completes with correct data.
- Reset/clear mid-frame:
  - i_reset=0 after 37 bytes: all outputs return to reset values, and the next 200 bytes form a correct frame.
  - Repeat with i_clear asserted in the same cycle as a byte arrives: the byte is dropped and no pulse occurs.
- Back-to-back: 256 consecutive frames with no idle. Required response: o_frame_done pulses 256 times, o_frame_count wraps to 0, no o_frame_error.
